// File: rtl/jtag_master_pkg.sv
// ---------------------------------------------------------------------------
// jtag_master_pkg
// Shared types and constants for the JTAG initiator:
//   - request type encoding (TAP reset / IR scan / DR scan)
//   - FSM state encoding
//   - TMS header patterns (LSB is driven first) and sequence lengths
//   - hdr_tms(): returns the TMS bit for a given header step
// ---------------------------------------------------------------------------
package jtag_master_pkg;

   typedef enum logic [1:0] {
      JTAG_RST = 2'd0,
      JTAG_IR  = 2'd1,
      JTAG_DR  = 2'd2
   } jtag_req_e;

   typedef logic [2:0] jtag_state_t;

   localparam jtag_state_t ST_INIT  = 3'd0;
   localparam jtag_state_t ST_IDLE  = 3'd1;
   localparam jtag_state_t ST_TLR   = 3'd2;
   localparam jtag_state_t ST_HDR   = 3'd3;
   localparam jtag_state_t ST_SHIFT = 3'd4;
   localparam jtag_state_t ST_EXIT  = 3'd5;
   localparam jtag_state_t ST_RTI   = 3'd6;
   localparam jtag_state_t ST_RESP  = 3'd7;

   // Run-Test/Idle -> Shift-IR is 1,1,0,0; Run-Test/Idle -> Shift-DR is 1,0,0.
   localparam logic [3:0] HDR_IR_TMS = 4'b0011;
   localparam logic [2:0] HDR_DR_TMS = 3'b001;
   localparam int unsigned HDR_IR_LEN = 4;
   localparam int unsigned HDR_DR_LEN = 3;
   // Five TMS=1 reach Test-Logic-Reset from any state, one TMS=0 parks in RTI.
   localparam int unsigned TLR_LEN    = 6;

   function automatic logic hdr_tms(input logic is_ir, input logic [1:0] idx);
      logic [3:0] pat;
      pat = is_ir ? HDR_IR_TMS : {1'b0, HDR_DR_TMS};
      return pat[idx];
   endfunction

endpackage

// File: rtl/jtag_tck_gen.sv
// ---------------------------------------------------------------------------
// jtag_tck_gen
// TCK divider. While en_i is high, TCK runs CLK_DIV clk_i cycles low then
// CLK_DIV cycles high. The strobes are high in the cycle whose closing clk_i
// edge starts the low phase (fall_stb_o) or raises TCK (rise_stb_o).
// When en_i is low the counter is cleared and TCK is held low.
// Ports:
//   clk_i, rst_i  clock, async active-high reset
//   en_i          run the divider
//   tck_o         divided clock (registered)
//   fall_stb_o    low phase begins at the next clk_i edge
//   rise_stb_o    TCK rises at the next clk_i edge
// ---------------------------------------------------------------------------
module jtag_tck_gen #(
   parameter int CLK_DIV = 4
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic en_i,
   output logic tck_o,
   output logic fall_stb_o,
   output logic rise_stb_o
);

   localparam int CNT_W = (CLK_DIV > 1) ? $clog2(2 * CLK_DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(2 * CLK_DIV - 1);
   localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLK_DIV);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             tck_q, tck_d;

   assign fall_stb_o = en_i && (cnt_q == '0);
   assign rise_stb_o = en_i && (cnt_q == CNT_HALF);
   assign tck_o      = tck_q;

   always_comb begin
      cnt_d = '0;
      tck_d = 1'b0;
      if (en_i) begin
         cnt_d = (cnt_q == CNT_MAX) ? '0 : cnt_q + CNT_W'(1);
         tck_d = rise_stb_o ? 1'b1 : (fall_stb_o ? 1'b0 : tck_q);
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cnt_q <= '0;
         tck_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         tck_q <= tck_d;
      end
   end

endmodule

// File: rtl/jtag_master.sv
// ---------------------------------------------------------------------------
// jtag_master
// JTAG initiator: runs the TAP init sequence after reset, then accepts TAP
// reset / IR scan / DR scan requests and returns the captured TDO bits.
// Ports:
//   clk_i, rst_i                  clock, async active-high reset
//   req_valid_i/req_ready_o       request handshake (ready only in IDLE)
//   req_type_i                    0 TAP reset, 1 IR scan, 2/3 DR scan
//   req_len_i                     shift length (0 -> 1, clamped to MAX_LEN)
//   req_data_i                    TDI bits, LSB first
//   rsp_valid_o/rsp_ready_i       response handshake
//   rsp_data_o                    captured TDO bits, right-aligned
//   tck_o, tms_o, tdi_o, tdo_i    JTAG pins
// ---------------------------------------------------------------------------
module jtag_master
   import jtag_master_pkg::*;
#(
   parameter int CLK_DIV = 4,
   parameter int MAX_LEN = 32,
   parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               req_valid_i,
   output logic               req_ready_o,
   input  logic [1:0]         req_type_i,
   input  logic [LEN_W-1:0]   req_len_i,
   input  logic [MAX_LEN-1:0] req_data_i,
   output logic               rsp_valid_o,
   input  logic               rsp_ready_i,
   output logic [MAX_LEN-1:0] rsp_data_o,
   output logic               tck_o,
   output logic               tms_o,
   output logic               tdi_o,
   input  logic               tdo_i
);

   localparam logic [LEN_W-1:0] STEP_ONE = LEN_W'(1);
   localparam logic [LEN_W-1:0] TLR_LAST = LEN_W'(TLR_LEN - 1);
   localparam logic [LEN_W-1:0] LEN_MAX  = LEN_W'(MAX_LEN);

   jtag_state_t        state_q, state_d;
   logic [LEN_W-1:0]   step_q, step_d;
   logic               done_q, done_d;
   logic               is_ir_q, is_ir_d;
   logic [LEN_W-1:0]   len_q, len_d;
   logic [MAX_LEN-1:0] data_q, data_d;
   logic [MAX_LEN-1:0] cap_q, cap_d;
   logic               tms_q, tms_d;
   logic               tdi_q, tdi_d;
   logic               rsp_valid_q, rsp_valid_d;
   logic [MAX_LEN-1:0] rsp_data_q, rsp_data_d;

   logic               tck_en, fall_stb, rise_stb;
   logic [LEN_W-1:0]   len_clamped, hdr_last, shamt;
   logic               shift_last;

   assign tck_en = (state_q != ST_IDLE) && (state_q != ST_RESP);

   jtag_tck_gen #(.CLK_DIV(CLK_DIV)) u_tck_gen (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .en_i       (tck_en),
      .tck_o      (tck_o),
      .fall_stb_o (fall_stb),
      .rise_stb_o (rise_stb)
   );

   assign len_clamped = (req_len_i == '0)     ? STEP_ONE :
                        (req_len_i > LEN_MAX) ? LEN_MAX  : req_len_i;
   assign hdr_last    = is_ir_q ? LEN_W'(HDR_IR_LEN - 1) : LEN_W'(HDR_DR_LEN - 1);
   assign shift_last  = (step_q == len_q - STEP_ONE);
   // Captured bits enter at the MSB; shift them down so bit 0 is the first one.
   assign shamt       = LEN_MAX - len_q;

   assign req_ready_o = (state_q == ST_IDLE);
   assign rsp_valid_o = rsp_valid_q;
   assign rsp_data_o  = rsp_data_q;
   assign tms_o       = tms_q;
   assign tdi_o       = tdi_q;

   always_comb begin
      state_d     = state_q;
      step_d      = step_q;
      done_d      = done_q;
      is_ir_d     = is_ir_q;
      len_d       = len_q;
      data_d      = data_q;
      cap_d       = cap_q;
      tms_d       = tms_q;
      tdi_d       = tdi_q;
      rsp_valid_d = rsp_valid_q;
      rsp_data_d  = rsp_data_q;
      case (state_q)
         ST_IDLE: begin
            if (req_valid_i) begin
               is_ir_d = (req_type_i == JTAG_IR);
               len_d   = len_clamped;
               data_d  = req_data_i;
               cap_d   = '0;
               step_d  = '0;
               done_d  = 1'b0;
               state_d = (req_type_i == JTAG_RST) ? ST_TLR : ST_HDR;
            end
         end
         ST_RESP: begin
            if (rsp_ready_i) begin
               rsp_valid_d = 1'b0;
               state_d     = ST_IDLE;
            end
         end
         default: begin
            if (fall_stb) begin
               // The last TCK cycle of a sequence completes its high phase
               // before leaving, so the next low phase ends the sequence.
               if (done_q) begin
                  done_d = 1'b0;
                  tms_d  = 1'b0;
                  tdi_d  = 1'b0;
                  if (state_q == ST_INIT) begin
                     state_d = ST_IDLE;
                  end else begin
                     state_d     = ST_RESP;
                     rsp_valid_d = 1'b1;
                     rsp_data_d  = (state_q == ST_TLR) ? '0 : (cap_q >> shamt);
                  end
               end else begin
                  tdi_d = 1'b0;
                  case (state_q)
                     ST_INIT, ST_TLR: tms_d = (step_q != TLR_LAST);
                     ST_HDR:          tms_d = hdr_tms(is_ir_q, step_q[1:0]);
                     ST_SHIFT: begin
                        tms_d = shift_last;
                        tdi_d = data_q[0];
                     end
                     ST_EXIT:         tms_d = 1'b1;
                     default:         tms_d = 1'b0;
                  endcase
               end
            end else if (rise_stb) begin
               case (state_q)
                  ST_INIT, ST_TLR: begin
                     if (step_q == TLR_LAST) done_d = 1'b1;
                     else                    step_d = step_q + STEP_ONE;
                  end
                  ST_HDR: begin
                     if (step_q == hdr_last) begin
                        state_d = ST_SHIFT;
                        step_d  = '0;
                     end else begin
                        step_d  = step_q + STEP_ONE;
                     end
                  end
                  ST_SHIFT: begin
                     cap_d  = {tdo_i, cap_q[MAX_LEN-1:1]};
                     data_d = data_q >> 1;
                     if (shift_last) begin
                        state_d = ST_EXIT;
                        step_d  = '0;
                     end else begin
                        step_d  = step_q + STEP_ONE;
                     end
                  end
                  ST_EXIT: state_d = ST_RTI;
                  default: done_d  = 1'b1;
               endcase
            end
         end
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q     <= ST_INIT;
         step_q      <= '0;
         done_q      <= 1'b0;
         is_ir_q     <= 1'b0;
         len_q       <= STEP_ONE;
         data_q      <= '0;
         cap_q       <= '0;
         tms_q       <= 1'b1;
         tdi_q       <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= '0;
      end else begin
         state_q     <= state_d;
         step_q      <= step_d;
         done_q      <= done_d;
         is_ir_q     <= is_ir_d;
         len_q       <= len_d;
         data_q      <= data_d;
         cap_q       <= cap_d;
         tms_q       <= tms_d;
         tdi_q       <= tdi_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_data_q  <= rsp_data_d;
      end
   end

endmodule

// File: tb/tb_jtag_master.sv
module tb_jtag_master;

   localparam int CLK_DIV = 2;
   localparam int MAX_LEN = 32;
   localparam int LEN_W   = 6;
   localparam logic [31:0] IDCODE_VAL = 32'h10000db3;
   localparam logic [4:0]  IR_IDCODE  = 5'b00001;

   logic               clk = 1'b0;
   logic               rst = 1'b0;
   logic               req_valid = 1'b0;
   logic               req_ready_o;
   logic [1:0]         req_type = 2'd0;
   logic [LEN_W-1:0]   req_len = '0;
   logic [MAX_LEN-1:0] req_data = '0;
   logic               rsp_valid_o;
   logic               rsp_ready = 1'b0;
   logic [MAX_LEN-1:0] rsp_data_o;
   logic               tck_o, tms_o, tdi_o;
   logic               tdo = 1'b0;

   int vectors = 0;
   int errors  = 0;

   always #5 clk = ~clk;

   jtag_master #(.CLK_DIV(CLK_DIV), .MAX_LEN(MAX_LEN), .LEN_W(LEN_W)) dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .req_valid_i (req_valid),
      .req_ready_o (req_ready_o),
      .req_type_i  (req_type),
      .req_len_i   (req_len),
      .req_data_i  (req_data),
      .rsp_valid_o (rsp_valid_o),
      .rsp_ready_i (rsp_ready),
      .rsp_data_o  (rsp_data_o),
      .tck_o       (tck_o),
      .tms_o       (tms_o),
      .tdi_o       (tdi_o),
      .tdo_i       (tdo)
   );

   // ---------------- behavioural TAP model (IR length 5) ----------------
   localparam int TLR = 0, RTI = 1, SELDR = 2, CAPDR = 3, SHDR = 4, EX1DR = 5,
                  PAUDR = 6, EX2DR = 7, UPDDR = 8, SELIR = 9, CAPIR = 10,
                  SHIR = 11, EX1IR = 12, PAUIR = 13, EX2IR = 14, UPDIR = 15;

   int          tap_st = TLR;
   logic [4:0]  ir = IR_IDCODE;
   logic [4:0]  ir_sr = '0;
   logic [31:0] dr = '0;
   logic        bp = 1'b0;

   int          edge_cnt = 0;
   logic [63:0] tms_vec = '0;
   logic [63:0] tdi_vec = '0;
   longint      last_rise = 0;
   longint      prev_rise = 0;

   function automatic int tap_next(input int s, input logic t);
      case (s)
         TLR:   return t ? TLR   : RTI;
         RTI:   return t ? SELDR : RTI;
         SELDR: return t ? SELIR : CAPDR;
         CAPDR: return t ? EX1DR : SHDR;
         SHDR:  return t ? EX1DR : SHDR;
         EX1DR: return t ? UPDDR : PAUDR;
         PAUDR: return t ? EX2DR : PAUDR;
         EX2DR: return t ? UPDDR : SHDR;
         UPDDR: return t ? SELDR : RTI;
         SELIR: return t ? TLR   : CAPIR;
         CAPIR: return t ? EX1IR : SHIR;
         SHIR:  return t ? EX1IR : SHIR;
         EX1IR: return t ? UPDIR : PAUIR;
         PAUIR: return t ? EX2IR : PAUIR;
         EX2IR: return t ? UPDIR : SHIR;
         default: return t ? SELDR : RTI;
      endcase
   endfunction

   always @(posedge tck_o) begin
      if (edge_cnt < 64) begin
         tms_vec[edge_cnt] = tms_o;
         tdi_vec[edge_cnt] = tdi_o;
      end
      edge_cnt  = edge_cnt + 1;
      prev_rise = last_rise;
      last_rise = $time;
      case (tap_st)
         TLR:   ir = IR_IDCODE;
         CAPDR: if (ir == IR_IDCODE) dr = IDCODE_VAL; else bp = 1'b0;
         SHDR:  if (ir == IR_IDCODE) dr = {tdi_o, dr[31:1]}; else bp = tdi_o;
         CAPIR: ir_sr = 5'b00001;
         SHIR:  ir_sr = {tdi_o, ir_sr[4:1]};
         UPDIR: ir = ir_sr;
         default: ;
      endcase
      tap_st = tap_next(tap_st, tms_o);
   end

   always @(negedge tck_o) begin
      if (tap_st == SHDR)      tdo <= (ir == IR_IDCODE) ? dr[0] : bp;
      else if (tap_st == SHIR) tdo <= ir_sr[0];
      else                     tdo <= 1'b0;
   end

   // ---------------- helpers driving stimulus ----------------
   task automatic issue(input logic [1:0] t, input logic [LEN_W-1:0] len, input logic [31:0] d);
      int n;
      n = 0;
      @(negedge clk);
      while (req_ready_o !== 1'b1 && n < 1000) begin
         @(negedge clk);
         n++;
      end
      vectors++;
      if (req_ready_o !== 1'b1) begin
         errors++;
         $display("FAIL issue_ready: req_ready_o=%b required 1", req_ready_o);
      end
      req_type  = t;
      req_len   = len;
      req_data  = d;
      req_valid = 1'b1;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      edge_cnt  = 0;
      tms_vec   = '0;
      tdi_vec   = '0;
   endtask

   task automatic wait_rsp(output logic [31:0] data);
      int n;
      n = 0;
      @(negedge clk);
      while (rsp_valid_o !== 1'b1 && n < 2000) begin
         @(negedge clk);
         n++;
      end
      vectors++;
      if (rsp_valid_o !== 1'b1) begin
         errors++;
         $display("FAIL rsp_timeout: rsp_valid_o=%b required 1", rsp_valid_o);
      end
      data = rsp_data_o;
   endtask

   task automatic take_rsp();
      @(negedge clk);
      rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      rsp_ready = 1'b0;
   endtask

   // Waits for req_ready after a reset release, flagging any response.
   task automatic wait_init(input string tag);
      int n;
      logic saw_rsp;
      n = 0;
      saw_rsp = 1'b0;
      while (req_ready_o !== 1'b1 && n < 500) begin
         @(negedge clk);
         if (rsp_valid_o !== 1'b0) saw_rsp = 1'b1;
         n++;
      end
      vectors++;
      if (req_ready_o !== 1'b1) begin
         errors++; $display("FAIL %s_ready: req_ready_o=%b required 1", tag, req_ready_o);
      end
      vectors++;
      if (saw_rsp !== 1'b0) begin
         errors++; $display("FAIL %s_no_rsp: rsp_valid_o seen=%b required 0", tag, saw_rsp);
      end
      vectors++;
      if (edge_cnt != 6) begin
         errors++; $display("FAIL %s_edges: got %0d required 6", tag, edge_cnt);
      end
      vectors++;
      if (tms_vec[5:0] !== 6'b011111) begin
         errors++; $display("FAIL %s_tms: got %b required 011111", tag, tms_vec[5:0]);
      end
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      #1 rst = 1'b1;
      repeat (3) @(negedge clk);
      vectors++;
      if ({tck_o, tms_o, tdi_o, req_ready_o, rsp_valid_o} !== 5'b01000) begin
         errors++;
         $display("FAIL reset_ctrl: tck,tms,tdi,ready,valid=%b required 01000",
                  {tck_o, tms_o, tdi_o, req_ready_o, rsp_valid_o});
      end
      vectors++;
      if (rsp_data_o !== 32'h0) begin
         errors++; $display("FAIL reset_data: got %h required 00000000", rsp_data_o);
      end
      rst = 1'b0;
      edge_cnt = 0;
      tms_vec  = '0;
      wait_init("init");
      vectors++;
      if (last_rise - prev_rise != 64'd40) begin
         errors++; $display("FAIL tck_period: got %0d required 40", last_rise - prev_rise);
      end
      vectors++;
      if (tap_st != RTI) begin
         errors++; $display("FAIL init_tap_state: got %0d required %0d", tap_st, RTI);
      end
   endtask

   task automatic test_ir_scan();
      logic [31:0] r;
      issue(2'd1, 6'd5, 32'h00000001);
      wait_rsp(r);
      vectors++;
      if (edge_cnt != 11) begin
         errors++; $display("FAIL ir_edges: got %0d required 11", edge_cnt);
      end
      vectors++;
      if (tms_vec[10:0] !== 11'b01100000011) begin
         errors++; $display("FAIL ir_tms: got %b required 01100000011", tms_vec[10:0]);
      end
      vectors++;
      if (tdi_vec[10:0] !== 11'b00000010000) begin
         errors++; $display("FAIL ir_tdi: got %b required 00000010000", tdi_vec[10:0]);
      end
      vectors++;
      if (r !== 32'h00000001) begin
         errors++; $display("FAIL ir_rsp: got %h required 00000001", r);
      end
      vectors++;
      if (ir !== 5'b00001) begin
         errors++; $display("FAIL ir_model: got %b required 00001", ir);
      end
      take_rsp();
   endtask

   task automatic test_idcode();
      logic [31:0] r;
      issue(2'd2, 6'd32, 32'h0);
      wait_rsp(r);
      vectors++;
      if (edge_cnt != 37) begin
         errors++; $display("FAIL idcode_edges: got %0d required 37", edge_cnt);
      end
      vectors++;
      if (tms_vec[36:0] !== 37'h0C00000001) begin
         errors++; $display("FAIL idcode_tms: got %h required 0c00000001", tms_vec[36:0]);
      end
      vectors++;
      if (r !== IDCODE_VAL) begin
         errors++; $display("FAIL idcode_rsp: got %h required %h", r, IDCODE_VAL);
      end
      take_rsp();
   endtask

   task automatic test_rsp_hold();
      logic [31:0] r;
      logic bad_v, bad_d, bad_r, bad_t;
      bad_v = 1'b0; bad_d = 1'b0; bad_r = 1'b0; bad_t = 1'b0;
      issue(2'd2, 6'd32, 32'hA5A50F0F);
      wait_rsp(r);
      vectors++;
      if (r !== IDCODE_VAL) begin
         errors++; $display("FAIL hold_rsp: got %h required %h", r, IDCODE_VAL);
      end
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (rsp_valid_o !== 1'b1) bad_v = 1'b1;
         if (rsp_data_o !== IDCODE_VAL) bad_d = 1'b1;
         if (req_ready_o !== 1'b0) bad_r = 1'b1;
         if (tck_o !== 1'b0) bad_t = 1'b1;
      end
      vectors++;
      if (bad_v !== 1'b0) begin errors++; $display("FAIL hold_valid: dropped=%b required 0", bad_v); end
      vectors++;
      if (bad_d !== 1'b0) begin errors++; $display("FAIL hold_data: changed=%b required 0", bad_d); end
      vectors++;
      if (bad_r !== 1'b0) begin errors++; $display("FAIL hold_ready: asserted=%b required 0", bad_r); end
      vectors++;
      if (bad_t !== 1'b0) begin errors++; $display("FAIL hold_tck: toggled=%b required 0", bad_t); end
      take_rsp();
      vectors++;
      if ({req_ready_o, rsp_valid_o} !== 2'b10) begin
         errors++; $display("FAIL hold_release: ready,valid=%b required 10", {req_ready_o, rsp_valid_o});
      end
   endtask

   task automatic test_len_edges();
      logic [31:0] r;
      issue(2'd2, 6'd0, 32'h00000001);
      wait_rsp(r);
      vectors++;
      if (edge_cnt != 6) begin errors++; $display("FAIL len0_edges: got %0d required 6", edge_cnt); end
      vectors++;
      if (r !== 32'h00000001) begin errors++; $display("FAIL len0_rsp: got %h required 00000001", r); end
      vectors++;
      if (tdi_vec[5:0] !== 6'b001000) begin
         errors++; $display("FAIL len0_tdi: got %b required 001000", tdi_vec[5:0]);
      end
      take_rsp();
      issue(2'd2, 6'd40, 32'h0);
      wait_rsp(r);
      vectors++;
      if (edge_cnt != 37) begin errors++; $display("FAIL len40_edges: got %0d required 37", edge_cnt); end
      vectors++;
      if (r !== IDCODE_VAL) begin errors++; $display("FAIL len40_rsp: got %h required %h", r, IDCODE_VAL); end
      take_rsp();
   endtask

   task automatic test_bypass_tlr();
      logic [31:0] r;
      issue(2'd1, 6'd5, 32'h0000001F);
      wait_rsp(r);
      vectors++;
      if (r !== 32'h00000001) begin errors++; $display("FAIL byp_ir_rsp: got %h required 00000001", r); end
      take_rsp();
      issue(2'd3, 6'd3, 32'h00000005);
      wait_rsp(r);
      vectors++;
      if (edge_cnt != 8) begin errors++; $display("FAIL byp_edges: got %0d required 8", edge_cnt); end
      vectors++;
      if (r !== 32'h00000002) begin errors++; $display("FAIL byp_rsp: got %h required 00000002", r); end
      take_rsp();
      issue(2'd0, 6'd7, 32'hFFFFFFFF);
      wait_rsp(r);
      vectors++;
      if (edge_cnt != 6) begin errors++; $display("FAIL tlr_edges: got %0d required 6", edge_cnt); end
      vectors++;
      if (tms_vec[5:0] !== 6'b011111) begin
         errors++; $display("FAIL tlr_tms: got %b required 011111", tms_vec[5:0]);
      end
      vectors++;
      if (r !== 32'h0) begin errors++; $display("FAIL tlr_rsp: got %h required 00000000", r); end
      vectors++;
      if (ir !== IR_IDCODE) begin errors++; $display("FAIL tlr_model_ir: got %b required 00001", ir); end
      take_rsp();
   endtask

   task automatic test_reset_mid();
      logic [31:0] r;
      int n;
      issue(2'd2, 6'd32, 32'h0);
      n = 0;
      while (edge_cnt < 15 && n < 500) begin @(negedge clk); n++; end
      n = 0;
      while (tck_o !== 1'b1 && n < 10) begin @(negedge clk); n++; end
      vectors++;
      if (tck_o !== 1'b1 || edge_cnt < 15) begin
         errors++; $display("FAIL mid_reach: tck_o=%b edges=%0d required 1 and >=15", tck_o, edge_cnt);
      end
      rst = 1'b1;
      #1;
      vectors++;
      if ({tck_o, tms_o, rsp_valid_o, req_ready_o} !== 4'b0100) begin
         errors++;
         $display("FAIL mid_async: tck,tms,valid,ready=%b required 0100",
                  {tck_o, tms_o, rsp_valid_o, req_ready_o});
      end
      repeat (3) @(negedge clk);
      rst = 1'b0;
      edge_cnt = 0;
      tms_vec  = '0;
      wait_init("reinit");
      issue(2'd2, 6'd32, 32'h0);
      wait_rsp(r);
      vectors++;
      if (r !== IDCODE_VAL) begin errors++; $display("FAIL mid_idcode: got %h required %h", r, IDCODE_VAL); end
      take_rsp();
   endtask

   initial begin
      test_reset();
      test_ir_scan();
      test_idcode();
      test_rsp_hold();
      test_len_edges();
      test_bypass_tlr();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule

// File: doc/jtag_master.md
Name: jtag_master

Overview:
- JTAG initiator that drives TCK/TMS/TDI toward a TAP controller and samples TDO.
- Accepts scan requests on a valid/ready interface: TAP reset, IR scan or DR scan of up to MAX_LEN bits.
- Walks the IEEE 1149.1 state sequence from Run-Test/Idle and back, then returns the captured TDO bits on a response interface.
- Used by the simulation harness and boot-debug paths to configure the TAP-side logic.

Parameters:
- CLK_DIV, 4, clk_i cycles per TCK half-period; minimum 1. TCK period = 2*CLK_DIV clk_i cycles.
- MAX_LEN, 32, maximum shift length in bits; also the data width.
- LEN_W, $clog2(MAX_LEN+1), width of the length field.

Ports:
- clk_i  in  1  system clock.
- rst_i  in  1  asynchronous, active-high reset.
- req_valid_i  in  1  request valid.
- req_ready_o  out  1  request accepted when valid&ready.
- req_type_i  in  2  0=TAP reset, 1=IR scan, 2=DR scan, 3=reserved (treated as DR).
- req_len_i  in  LEN_W  shift length in bits.
- req_data_i  in  MAX_LEN  TDI data, LSB shifted first.
- rsp_valid_o  out  1  response valid.
- rsp_ready_i  in  1  response consumed when valid&ready.
- rsp_data_o  out  MAX_LEN  captured TDO bits, right-aligned.
- tck_o  out  1  JTAG clock.
- tms_o  out  1  JTAG mode select.
- tdi_o  out  1  JTAG data to target.
- tdo_i  in  1  JTAG data from target.

Behaviour:
- Interface is one clock domain and one reset: clk_i, with rst_i asynchronous and active-high.
- Reset values: tck_o=0, tms_o=1, tdi_o=0, req_ready_o=0, rsp_valid_o=0, rsp_data_o=0. FSM state = INIT.
- TCK generation:
  - TCK toggles only while a sequence is active; it is held low in IDLE and RESP.
  - Each TCK cycle is CLK_DIV clk_i cycles low, then CLK_DIV clk_i cycles high.
  - tms_o and tdi_o update on the clk_i edge that begins the low phase.
  - tdo_i is sampled on the clk_i edge that raises tck_o.
- FSM states: INIT, IDLE, TLR, HDR, SHIFT, EXIT, RTI, RESP.
- INIT (after every reset): TMS 1,1,1,1,1,0 (6 TCK cycles), then IDLE. No response is produced.
- IDLE: req_ready_o=1 only in IDLE; the request is latched on handshake.
- Length rules: len 0 is treated as 1; len > MAX_LEN is clamped to MAX_LEN.
- TAP reset request: TLR sequence, TMS 1 x5 then 0 (6 cycles), then RESP with rsp_data_o=0.
- IR scan: HDR TMS 1,1,0,0; SHIFT len cycles with TMS=0 except TMS=1 on the last; EXIT TMS 1; RTI TMS 0. Total = len+6 TCK cycles.
- DR scan: HDR TMS 1,0,0; otherwise identical to IR scan. Total = len+5 TCK cycles.
- SHIFT data path:
  - tdi_o = data bit i during shift cycle i.
  - The TDO sampled at shift cycle i lands in rsp_data_o[i].
  - Bits at index >= len are 0.
  - tdi_o=0 outside SHIFT.
- RESP:
  - rsp_valid_o=1; rsp_data_o is held stable until rsp_ready_i.
  - rsp_valid_o and rsp_data_o are registered.
  - Go to IDLE on the handshake cycle.
  - No new request is accepted before the response handshake, so there is no overlap.
- Reset mid-operation: all outputs go to their reset values immediately (asynchronously), pending data and response are discarded, and the INIT sequence reruns.
- tms_o at rest is 0 in IDLE and RESP.

Decomposition:
- jtag_master_pkg holds:
  - the req_type enum (JTAG_RST, JTAG_IR, JTAG_DR);
  - the FSM state enum;
  - header TMS constants and lengths: IR 4'b0011 (LSB first), length 4; DR 3'b001, length 3; TLR length 6.
- Sub-module jtag_tck_gen: divider counter producing tck_o plus one-cycle fall_stb and rise_stb strobes, with an enable input. When disabled, the counter resets and TCK is held low.
- jtag_master holds the FSM, bit counter, shift and capture registers, and request/response registers.

Test Plan:
All scenarios use CLK_DIV=2, MAX_LEN=32, and a bench behavioural TAP model with IR length 5 and IDCODE 32'h10000db3.
1. Release reset -> exactly 6 TCK rising edges with TMS 1,1,1,1,1,0. TCK period is 4 clk_i cycles. req_ready_o rises after the sequence; rsp_valid_o stays 0.
2. IR scan, len 5, data 5'b00001 -> TMS per edge 1,1,0,0,0,0,0,0,1,1,0 (11 edges). TDI on shift edges 1,0,0,0,0. The model's IR is 5'b00001. rsp_data_o = 32'h00000001, matching the model's capture value 5'b00001.
3. DR scan, len 32, data 0 after IR=IDCODE -> 37 TCK edges; rsp_data_o = 32'h10000db3.
4. rsp_ready_i held low for 20 cycles after rsp_valid_o -> rsp_valid_o and rsp_data_o stable, req_ready_o=0, tck_o=0 throughout. Release -> IDLE next cycle.
5. DR scans with len 0 and len 40 -> 6 and 37 TCK edges respectively; rsp_data_o upper bits zero above the clamped length.
6. Assert rst_i midway through a 32-bit DR shift -> tck_o=0 and tms_o=1 in the same cycle (asynchronous), rsp_valid_o stays 0. After release the 6-edge INIT sequence reruns and a following IDCODE DR scan returns 32'h10000db3.
